// File: rtl/instr_fetch.sv
// instr_fetch: fetches 32-bit words from a synchronous-read RAM and hands them one at a time to the core
module instr_fetch #(
  parameter int          PC_WIDTH = 11,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_rden,
  input  logic [31:0]         imem_rddata,
  input  logic                waiting,
  input  logic                branch_en,
  input  logic [31:0]         branch_target,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [31:0]         instr_pc,
  output logic [31:0]         fetch_count
);
  typedef enum logic [1:0] {S_REQ, S_RESP, S_HOLD} state_t;
  state_t state, state_nx;
  logic [31:0] pc;
  assign imem_addr = pc[PC_WIDTH+1:2];
  assign imem_rden = state == S_REQ;
  // next state: a redirect always restarts with a request, otherwise request -> response -> hold until consumed
  always_comb begin
    state_nx = state;
    state_nx = branch_en ? S_REQ :
               state == S_REQ ? S_RESP :
               state == S_RESP ? S_HOLD :
               waiting ? S_REQ : S_HOLD;
  end
  // state and datapath; a redirect outranks capture and consume so stale data and dropped words never count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_nx;
      if (branch_en) begin
        pc          <= branch_target & ~32'd3;
        instr_valid <= 1'b0;
      end else if (state == S_RESP) begin
        instr       <= imem_rddata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + 32'd4;
      end else if (state == S_HOLD && waiting) begin
        instr_valid <= 1'b0;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table plus hand sequences for the fetch stage
module tb_instr_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, waiting, branch_en, imem_rden, instr_valid;
  logic [31:0] branch_target, imem_rddata, instr, instr_pc, fetch_count;
  logic [10:0] imem_addr;
  logic [31:0] mem [2048];
  logic        rst2_n, wait2, br2, rden2, v2;
  logic [31:0] tgt2, rd2, instr2, ipc2, cnt2;
  logic [1:0]  addr2;
  logic [31:0] mem2 [4];
  int tests = 0, fails = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rden(imem_rden),
    .imem_rddata(imem_rddata), .waiting(waiting), .branch_en(branch_en),
    .branch_target(branch_target), .instr(instr), .instr_valid(instr_valid),
    .instr_pc(instr_pc), .fetch_count(fetch_count)
  );
  instr_fetch #(.PC_WIDTH(2), .RESET_PC(32'hC)) dut2 (
    .clk(clk), .rst_n(rst2_n), .imem_addr(addr2), .imem_rden(rden2),
    .imem_rddata(rd2), .waiting(wait2), .branch_en(br2),
    .branch_target(tgt2), .instr(instr2), .instr_valid(v2),
    .instr_pc(ipc2), .fetch_count(cnt2)
  );

  always @(posedge clk) if (imem_rden) imem_rddata <= mem[imem_addr];
  always @(posedge clk) if (rden2) rd2 <= mem2[addr2];

  typedef struct {
    logic [31:0] rst_n, w, br, tgt, v, ins, ipc, cnt, rden;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [31:0] r, w, br, tgt, v, ins, ipc, cnt, rden);
    vec_t x;
    x.rst_n = r; x.w = w; x.br = br; x.tgt = tgt;
    x.v = v; x.ins = ins; x.ipc = ipc; x.cnt = cnt; x.rden = rden;
    tbl.push_back(x);
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hDEAD_0000 | i;
    mem[0] = 32'hE3A00001; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[4] = 32'h55; mem[5] = 32'h66; mem[16] = 32'hAA; mem[2047] = 32'hCC;
    mem2[0] = 32'hA0; mem2[1] = 32'hA1; mem2[2] = 32'hA2; mem2[3] = 32'hA3;
    rst_n = 0; waiting = 0; branch_en = 0; branch_target = 0;
    rst2_n = 0; wait2 = 0; br2 = 0; tgt2 = 0;

    // reset fetch of the first word, then a long hold with waiting low
    step;
    chk("rst valid", 32'(instr_valid), 0);
    chk("rst instr", instr, 0);
    chk("rst count", fetch_count, 0);
    chk("rst rden", 32'(imem_rden), 1);
    rst_n = 1;
    step;
    chk("lat1 valid", 32'(instr_valid), 0);
    step;
    chk("lat2 valid", 32'(instr_valid), 1);
    chk("lat2 instr", instr, 32'hE3A00001);
    chk("lat2 pc", instr_pc, 0);
    for (int i = 0; i < 10; i++) begin
      step;
      chk($sformatf("hold%0d valid", i), 32'(instr_valid), 1);
      chk($sformatf("hold%0d instr", i), instr, 32'hE3A00001);
      chk($sformatf("hold%0d count", i), fetch_count, 0);
      chk($sformatf("hold%0d rden", i), 32'(imem_rden), 0);
    end
    mem[0] = 32'h11;

    // rst w br tgt | valid instr instr_pc count rden, state after the edge
    add(0,1,0,0,           0,0,0,0,1);
    add(1,1,0,0,           0,0,0,0,0);
    add(1,1,0,0,           1,32'h11,0,0,0);
    add(1,1,0,0,           0,32'h11,0,1,1);
    add(1,1,0,0,           0,32'h11,0,1,0);
    add(1,1,0,0,           1,32'h22,4,1,0);
    add(1,1,0,0,           0,32'h22,4,2,1);
    add(1,1,0,0,           0,32'h22,4,2,0);
    add(1,1,0,0,           1,32'h33,8,2,0);
    add(1,1,0,0,           0,32'h33,8,3,1);
    add(1,1,0,0,           0,32'h33,8,3,0);
    add(1,1,0,0,           1,32'h44,12,3,0);
    add(1,1,0,0,           0,32'h44,12,4,1);
    add(0,0,0,0,           0,0,0,0,1);
    add(1,0,0,0,           0,0,0,0,0);
    add(1,0,0,0,           1,32'h11,0,0,0);
    add(1,1,1,32'h13,      0,32'h11,0,0,1);
    add(1,0,0,0,           0,32'h11,0,0,0);
    add(1,0,0,0,           1,32'h55,32'h10,0,0);
    add(1,1,0,0,           0,32'h55,32'h10,1,1);
    add(1,0,0,0,           0,32'h55,32'h10,1,0);
    add(1,0,1,32'h40,      0,32'h55,32'h10,1,1);
    add(1,0,0,0,           0,32'h55,32'h10,1,0);
    add(1,0,0,0,           1,32'hAA,32'h40,1,0);
    add(1,0,1,32'hFFFFFFFC,0,32'hAA,32'h40,1,1);
    add(1,0,0,0,           0,32'hAA,32'h40,1,0);
    add(1,0,0,0,           1,32'hCC,32'hFFFFFFFC,1,0);
    add(1,1,0,0,           0,32'hCC,32'hFFFFFFFC,2,1);
    add(1,0,0,0,           0,32'hCC,32'hFFFFFFFC,2,0);
    add(1,0,0,0,           1,32'h11,0,2,0);
    add(1,1,0,0,           0,32'h11,0,3,1);
    add(1,0,0,0,           0,32'h11,0,3,0);
    add(0,1,1,32'h80,      0,0,0,0,1);
    add(1,0,0,0,           0,0,0,0,0);
    add(1,0,0,0,           1,32'h11,0,0,0);
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n[0]; waiting = tbl[i].w[0];
      branch_en = tbl[i].br[0]; branch_target = tbl[i].tgt;
      step;
      chk($sformatf("vec%0d valid", i), 32'(instr_valid), tbl[i].v);
      chk($sformatf("vec%0d instr", i), instr, tbl[i].ins);
      chk($sformatf("vec%0d instr_pc", i), instr_pc, tbl[i].ipc);
      chk($sformatf("vec%0d count", i), fetch_count, tbl[i].cnt);
      chk($sformatf("vec%0d rden", i), 32'(imem_rden), tbl[i].rden);
    end
    waiting = 0; branch_en = 0;

    // small RAM: last word is followed by word 0
    wait2 = 1;
    step;
    chk("wrap addr3", 32'(addr2), 3);
    chk("wrap rden", 32'(rden2), 1);
    rst2_n = 1;
    step;
    step;
    chk("wrap valid1", 32'(v2), 1);
    chk("wrap pc1", ipc2, 32'hC);
    chk("wrap instr1", instr2, 32'hA3);
    step;
    chk("wrap addr0", 32'(addr2), 0);
    step;
    step;
    chk("wrap pc2", ipc2, 32'h10);
    chk("wrap instr2", instr2, 32'hA0);
    chk("wrap count", cnt2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
